// File: rtl/rseq_pkg.sv
// rseq_pkg: shared state encoding and counter sizing for the reset sequencer
package rseq_pkg;
  localparam int RSEQ_STATE_W = 2;
  localparam logic [RSEQ_STATE_W-1:0] RSEQ_HOLD = 2'd0;
  localparam logic [RSEQ_STATE_W-1:0] RSEQ_WAIT = 2'd1;
  localparam logic [RSEQ_STATE_W-1:0] RSEQ_DONE = 2'd2;
  typedef enum logic [RSEQ_STATE_W-1:0] {
    ST_HOLD = RSEQ_HOLD,
    ST_WAIT = RSEQ_WAIT,
    ST_DONE = RSEQ_DONE
  } rseq_state_e;
  function automatic int rseq_cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/rseq_sat_counter.sv
// rseq_sat_counter: up-counter with synchronous clear that sticks at all-ones
module rseq_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all stages in reset, then releases them one by one as each reports ready.
// Define RSEQ_TIMEOUT_EN to bound each ready wait and flag a sticky timeout_err.
module reset_sequencer
  import rseq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGE_DELAY    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stage_ready_in,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] stage_reset_out,
  output logic                  all_released,
  output logic                  busy,
  output logic                  timeout_err
);
`ifdef RSEQ_TIMEOUT_EN
  localparam int CW = rseq_cnt_w(HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES);
`else
  localparam int CW = rseq_cnt_w(HOLD_CYCLES > STAGE_DELAY ? HOLD_CYCLES : STAGE_DELAY);
`endif
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("reset_sequencer: parameters must all be >= 1");
  end

  rseq_state_e          state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] out_d;
  logic                  rel_d, busy_d, tmo_d;
  logic [CW-1:0]         cnt;
  logic                  cnt_clr, cnt_en, accept, tmo_hit, adv;

  rseq_sat_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt)
  );

  // Ready is level-sampled, so an early flag simply waits out the minimum delay.
  assign accept = cnt >= DLY_LAST && stage_ready_in[idx_q];
`ifdef RSEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  if (TIMEOUT_CYCLES <= STAGE_DELAY) begin : g_bad_tmo
    $error("reset_sequencer: TIMEOUT_CYCLES must exceed STAGE_DELAY");
  end
  assign tmo_hit = cnt == TMO_LAST && !accept;
`else
  assign tmo_hit = 1'b0;
`endif
  assign adv = accept || tmo_hit;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = stage_reset_out;
    rel_d   = all_released;
    busy_d  = busy;
    tmo_d   = timeout_err;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_HOLD: begin
        cnt_en = 1'b1;
        if (cnt == HOLD_LAST) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          out_d   = NUM_STAGES'(1);
          cnt_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        tmo_d  = timeout_err || tmo_hit;
        if (adv) begin
          cnt_clr = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            rel_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            out_d = (stage_reset_out << 1) | NUM_STAGES'(1);
          end
        end
      end
      ST_DONE: begin
        if (sw_reset_req) begin
          state_d = ST_HOLD;
          idx_d   = '0;
          out_d   = '0;
          rel_d   = 1'b0;
          busy_d  = 1'b1;
          tmo_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        idx_d   = '0;
        out_d   = '0;
        rel_d   = 1'b0;
        busy_d  = 1'b1;
        tmo_d   = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q         <= ST_HOLD;
      idx_q           <= '0;
      stage_reset_out <= '0;
      all_released    <= 1'b0;
      busy            <= 1'b1;
      timeout_err     <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      stage_reset_out <= out_d;
      all_released    <= rel_d;
      busy            <= busy_d;
      timeout_err     <= tmo_d;
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed vectors with hand-computed release timing for the default parameters
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] stage_ready_in;
  logic       sw_reset_req;
  logic [2:0] stage_reset_out;
  logic       all_released, busy, timeout_err;
  int n_vec = 0;
  int n_err = 0;

  reset_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stage_ready_in  (stage_ready_in),
    .sw_reset_req    (sw_reset_req),
    .stage_reset_out (stage_reset_out),
    .all_released    (all_released),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Edge e counts rising edges since the sequence restarted from HOLD with cnt=0.
  task automatic run_seq(input string tag);
    for (int e = 1; e <= 40; e++) begin
      tick();
      check($sformatf("%s_out_e%0d", tag, e), 32'(stage_reset_out),
            e >= 32 ? 32'd7 : e >= 24 ? 32'd3 : e >= 16 ? 32'd1 : 32'd0);
      check($sformatf("%s_busy_e%0d", tag, e), 32'(busy), e >= 40 ? 32'd0 : 32'd1);
      check($sformatf("%s_rel_e%0d", tag, e), 32'(all_released), e >= 40 ? 32'd1 : 32'd0);
    end
    check({tag, "_tmo"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    stage_ready_in = 3'b111;
    sw_reset_req = 1'b0;
    repeat (3) tick();
    check("rst_out", 32'(stage_reset_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rel", 32'(all_released), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);

    reset = 1'b1;
    run_seq("t1");

    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("t3_out", 32'(stage_reset_out), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_rel", 32'(all_released), 32'd0);
    run_seq("t3");

    restart();
    stage_ready_in = 3'b101;
    for (int e = 1; e <= 74; e++) begin
      sw_reset_req = (e == 40);
      tick();
      check($sformatf("t2_out_e%0d", e), 32'(stage_reset_out),
            e >= 24 ? 32'd3 : e >= 16 ? 32'd1 : 32'd0);
    end
    sw_reset_req = 1'b0;
    stage_ready_in = 3'b111;
    tick();
    check("t2_out_e75", 32'(stage_reset_out), 32'd7);
    for (int e = 76; e <= 83; e++) begin
      tick();
      check($sformatf("t2_busy_e%0d", e), 32'(busy), e >= 83 ? 32'd0 : 32'd1);
      check($sformatf("t2_rel_e%0d", e), 32'(all_released), e >= 83 ? 32'd1 : 32'd0);
    end

    restart();
    repeat (28) tick();
    check("t4_pre_out", 32'(stage_reset_out), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("t4_async_out", 32'(stage_reset_out), 32'd0);
    check("t4_async_busy", 32'(busy), 32'd1);
    check("t4_async_rel", 32'(all_released), 32'd0);
    tick();
    reset = 1'b1;
    run_seq("t4");

`ifdef RSEQ_TIMEOUT_EN
    restart();
    stage_ready_in = 3'b110;
    for (int e = 1; e <= 287; e++) begin
      tick();
      check($sformatf("t5_out_e%0d", e), 32'(stage_reset_out),
            e >= 279 ? 32'd7 : e >= 271 ? 32'd3 : e >= 16 ? 32'd1 : 32'd0);
      check($sformatf("t5_tmo_e%0d", e), 32'(timeout_err), e >= 271 ? 32'd1 : 32'd0);
      check($sformatf("t5_rel_e%0d", e), 32'(all_released), e >= 287 ? 32'd1 : 32'd0);
    end
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("t5_clr_tmo", 32'(timeout_err), 32'd0);
`else
    restart();
    stage_ready_in = 3'b110;
    for (int c = 1; c <= 1000; c++) begin
      sw_reset_req = (c % 97 == 0);
      tick();
      check($sformatf("t6_out_c%0d", c), 32'(stage_reset_out), c >= 16 ? 32'd1 : 32'd0);
      check($sformatf("t6_busy_c%0d", c), 32'(busy), 32'd1);
      check($sformatf("t6_tmo_c%0d", c), 32'(timeout_err), 32'd0);
    end
    sw_reset_req = 1'b0;
    stage_ready_in = 3'b111;
    tick();
    check("t6_resume_out", 32'(stage_reset_out), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
